alu_seq: RTL and testbench

Parametrised, sequential successor to the 4-bit select-driven ALU/MUX datapath. It takes operand pairs through a valid/ready input handshake and executes one operation per transaction: single-cycle logic/arithmetic, or a multi-cycle shift-add unsigned multiply. It presents a registered result plus status flags through a valid/ready output handshake. It sits between the operand source (register file or bench driver) and the result consumer.

---
 rtl/alu_seq_pkg.sv | 64 ++++++
 rtl/alu_seq_mul.sv | 56 +++++
 rtl/alu_seq.sv | 112 +++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode encoding, FSM states and the single-cycle ALU evaluation used by alu_seq.
// The ALU function works on a MAX_W-wide zero-extended operand, with msb selecting the live width.
package alu_seq_pkg;

  localparam int OP_W  = 3;
  localparam int MAX_W = 32;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             carry;
    logic             ovf;
    logic             err;
  } alu_res_t;

  function automatic alu_res_t alu_op(input logic [OP_W-1:0]  op,
                                      input logic [MAX_W-1:0] a,
                                      input logic [MAX_W-1:0] b,
                                      input logic [4:0]       msb);
    alu_res_t         r;
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] mask;
    logic             b_sign;
    r      = '0;
    sum    = '0;
    b_sign = 1'b0;
    mask   = {MAX_W{1'b1}} >> (5'(MAX_W - 1) - msb);
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        b_sign = b[msb];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        b_sign = ~b[msb];
      end
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_XOR:  r.res = a ^ b;
      OP_MUL:  r.res = '0;
      default: r.err = 1'b1;
    endcase
    // Operands are zero-extended, so bit msb+1 of the wide sum is the carry (or borrow for SUB).
    if (op == OP_ADD || op == OP_SUB) begin
      r.res   = sum[MAX_W-1:0] & mask;
      r.carry = sum[{1'b0, msb} + 6'd1];
      r.ovf   = (a[msb] == b_sign) && (sum[msb] != a[msb]);
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH steps.
// done is a one-cycle pulse in the cycle after the last step, when prod holds the full product.
module alu_seq_mul
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= (cnt == CW'(1)) && !start;
      if (start) begin
        cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign busy = (cnt != '0) || done;
  assign prod = acc;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready on both sides: single-cycle logic/arithmetic ops and a
// multi-cycle unsigned multiply, result and flags held in DONE until the consumer takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res_o,
  output logic               zero_o,
  output logic               carry_o,
  output logic               ovf_o,
  output logic               neg_o,
  output logic               err_o
);

  localparam int RW = 2 * WIDTH;

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          is_mul;
  logic          mul_start;
  logic          mul_busy;
  logic          mul_done;
  logic [RW-1:0] mul_prod;
  alu_res_t      alu_r;
  logic [RW-1:0] alu_res;

  assign is_mul    = (op_i == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul;
  assign alu_r     = alu_op(op_i, MAX_W'(a_i), MAX_W'(b_i), 5'(WIDTH - 1));
  assign alu_res   = RW'(alu_r.res);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a_i),
    .b     (b_i),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = is_mul ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: begin
        if (mul_done)      next_state = ST_DONE;
        else if (!mul_busy) next_state = ST_IDLE;
      end
      ST_DONE: begin
        if (accept)         next_state = is_mul ? ST_BUSY : ST_DONE;
        else if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
  end

  // Result/flag register: loaded on a single-cycle accept or when the multiplier finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_o   <= '0;
      zero_o  <= 1'b0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
      neg_o   <= 1'b0;
      err_o   <= 1'b0;
    end else if (accept && !is_mul) begin
      res_o   <= alu_res;
      zero_o  <= (alu_res == '0);
      carry_o <= alu_r.carry;
      ovf_o   <= alu_r.ovf;
      neg_o   <= alu_res[WIDTH-1];
      err_o   <= alu_r.err;
    end else if ((state == ST_BUSY) && mul_done) begin
      res_o   <= mul_prod;
      zero_o  <= (mul_prod == '0);
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
      neg_o   <= mul_prod[RW-1];
      err_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=4): hand-written latency/backpressure/reset sequences plus a
// vector table, with results checked through an in-order scoreboard queue.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op_i;
  logic [3:0] a_i;
  logic [3:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] res_o;
  logic       zero_o, carry_o, ovf_o, neg_o, err_o;

  alu_seq #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_o     (res_o),
    .zero_o    (zero_o),
    .carry_o   (carry_o),
    .ovf_o     (ovf_o),
    .neg_o     (neg_o),
    .err_o     (err_o)
  );

  always #5 clk = ~clk;

  // flg packs {zero, carry, ovf, neg, err}
  typedef struct {
    logic [7:0] res;
    logic [4:0] flg;
  } exp_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    logic [4:0] flg;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res %0h with nothing outstanding", res_o);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_res", 16'(res_o), 16'(mon_e.res));
        chk("sb_flags", 16'({zero_o, carry_o, ovf_o, neg_o, err_o}), 16'(mon_e.flg));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input exp_t e);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    op_i = op;
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required accept", n);
    end else begin
      sb_q.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required end of test");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op_i = '0;
    a_i = '0;
    b_i = '0;

    vecs[0]  = '{OP_ADD, 4'b1011, 4'b0011, 8'h0E, 5'b00010};
    vecs[1]  = '{OP_SUB, 4'b0011, 4'b1011, 8'h08, 5'b01110};
    vecs[2]  = '{OP_MUL, 4'b1011, 4'b0011, 8'h21, 5'b00000};
    vecs[3]  = '{OP_AND, 4'b1100, 4'b1010, 8'h08, 5'b00010};
    vecs[4]  = '{OP_XOR, 4'b1100, 4'b1010, 8'h06, 5'b00000};
    vecs[5]  = '{3'b111, 4'b1111, 4'b1111, 8'h00, 5'b10001};
    vecs[6]  = '{OP_ADD, 4'b0111, 4'b0001, 8'h08, 5'b00110};
    vecs[7]  = '{OP_ADD, 4'b1111, 4'b0001, 8'h00, 5'b11000};
    vecs[8]  = '{OP_SUB, 4'b0101, 4'b0101, 8'h00, 5'b10000};
    vecs[9]  = '{OP_SUB, 4'b1000, 4'b0001, 8'h07, 5'b00100};
    vecs[10] = '{OP_OR,  4'b0101, 4'b0010, 8'h07, 5'b00000};
    vecs[11] = '{OP_MUL, 4'b1111, 4'b1111, 8'hE1, 5'b00010};
    vecs[12] = '{OP_MUL, 4'b0000, 4'b1010, 8'h00, 5'b10000};
    vecs[13] = '{3'b110, 4'b0011, 4'b0101, 8'h00, 5'b10001};
    vecs[14] = '{OP_ADD, 4'b1000, 4'b1000, 8'h00, 5'b11100};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 16'(out_valid), 16'd0);
    chk("reset_in_ready", 16'(in_ready), 16'd1);
    chk("reset_res", 16'(res_o), 16'd0);
    chk("reset_flags", 16'({zero_o, carry_o, ovf_o, neg_o, err_o}), 16'd0);

    // ADD: result visible one cycle after the accept edge
    op_i = OP_ADD; a_i = 4'b1011; b_i = 4'b0011; in_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back('{8'h0E, 5'b00010});
    in_valid = 1'b0;
    chk("add_latency_valid", 16'(out_valid), 16'd1);
    @(posedge clk); #1;
    chk("add_release_valid", 16'(out_valid), 16'd0);
    chk("add_release_ready", 16'(in_ready), 16'd1);

    // MUL: in_ready low while busy, competing in_valid ignored, result after WIDTH+1 edges
    op_i = OP_MUL; a_i = 4'b1011; b_i = 4'b0011; in_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back('{8'h21, 5'b00000});
    op_i = OP_ADD; a_i = 4'b0001; b_i = 4'b0001;
    chk("mul_busy_ready", 16'(in_ready), 16'd0);
    chk("mul_wait_valid", 16'(out_valid), 16'd0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("mul_wait_valid", 16'(out_valid), 16'd0);
      chk("mul_busy_ready", 16'(in_ready), 16'd0);
      if (k == 4) in_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("mul_latency_valid", 16'(out_valid), 16'd1);
    chk("mul_res", 16'(res_o), 16'h21);
    @(posedge clk); #1;

    // Backpressure: AND held for 3 cycles, then XOR accepted in the hand-off cycle
    out_ready = 1'b0;
    op_i = OP_AND; a_i = 4'b1100; b_i = 4'b1010; in_valid = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back('{8'h08, 5'b00010});
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_res", 16'(res_o), 16'h08);
      chk("bp_ready", 16'(in_ready), 16'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    op_i = OP_XOR; in_valid = 1'b1;
    #1;
    chk("b2b_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    sb_q.push_back('{8'h06, 5'b00000});
    in_valid = 1'b0;
    chk("b2b_valid", 16'(out_valid), 16'd1);
    chk("b2b_res", 16'(res_o), 16'h06);
    @(posedge clk); #1;

    // Table vectors issued back to back
    for (int i = 0; i < 15; i++) begin
      e.res = vecs[i].res;
      e.flg = vecs[i].flg;
      send(vecs[i].op, vecs[i].a, vecs[i].b, e);
    end
    for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain", 16'(sb_q.size()), 16'd0);

    // Reset during a MUL: no result may ever appear for it
    e.res = 8'h02;
    e.flg = 5'b00000;
    send(OP_ADD, 4'b0001, 4'b0001, e);
    @(posedge clk); #1;
    op_i = OP_MUL; a_i = 4'b1111; b_i = 4'b1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mul_valid", 16'(out_valid), 16'd0);
    chk("rst_mul_res", 16'(res_o), 16'd0);
    chk("rst_mul_ready", 16'(in_ready), 16'd1);
    chk("rst_mul_flags", 16'({zero_o, carry_o, ovf_o, neg_o, err_o}), 16'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", 16'(out_valid), 16'd0);
    end
    chk("final_queue", 16'(sb_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
